// File: rtl/pacman_mem_arbiter.sv
// CPU/GPU arbiter and address decoder for ROM, work RAM and dual-port frame buffer; GPU owns FB port A by priority.
// Optional MM_STARVE_GUARD_EN: after STARVE_MAX denied CPU FB cycles the CPU is forced onto port A.
module pacman_mem_arbiter #(
  parameter int          ROM_AW     = 14,
  parameter int          FB_AW      = 11,
  parameter int          RAM_AW     = 12,
  parameter logic [15:0] FB_BASE    = 16'h4000,
  parameter logic [15:0] RAM_BASE   = 16'h4800,
  parameter logic [15:0] RAM_TOP    = 16'h50FF,
  parameter int          STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [15:0]       cpu_addr,
  input  logic              cpu_mreq_n,
  input  logic              cpu_wr_n,
  input  logic              gpu_req,
  input  logic [FB_AW-1:0]  gpu_addr_a,
  input  logic [FB_AW-1:0]  gpu_addr_b,
  output logic              rom_en,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              fb_en_a,
  output logic              fb_we_a,
  output logic [FB_AW-1:0]  fb_addr_a,
  output logic              fb_en_b,
  output logic [FB_AW-1:0]  fb_addr_b,
  output logic              gpu_grant,
  output logic [1:0]        rd_sel,
  output logic              rd_valid,
  output logic              cpu_wait_n,
  output logic              bus_err
);

  typedef enum logic {IDLE, ACK} state_t;

  localparam logic [1:0] SEL_ROM = 2'd0;
  localparam logic [1:0] SEL_RAM = 2'd1;
  localparam logic [1:0] SEL_FB  = 2'd2;
  localparam logic [1:0] SEL_UNM = 2'd3;

  localparam int ROM_END = (1 << ROM_AW) - 1;
  localparam int FB_LO   = int'(FB_BASE);
  localparam int FB_HI   = int'(FB_BASE) + (1 << FB_AW) - 1;
  localparam int RAM_LO  = int'(RAM_BASE);
  localparam int RAM_HI  = int'(RAM_TOP);

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve
    $error("STARVE_MAX out of range 1..15");
  end

  state_t      state, next_state;
  logic [15:0] lat_addr;
  logic        lat_wr_n;
  logic        first_ack;
  logic [15:0] acc_addr;
  logic [1:0]  region;
  logic        guard_fire;
  int          acc_int;

  // During ACK the access is served from the latched address, not the live bus.
  assign acc_addr = (state == ACK) ? lat_addr : cpu_addr;
  assign acc_int  = {16'd0, acc_addr};

  always_comb begin
    region = SEL_UNM;
    if (acc_int <= ROM_END)                          region = SEL_ROM;
    else if (acc_int >= FB_LO && acc_int <= FB_HI)   region = SEL_FB;
    else if (acc_int >= RAM_LO && acc_int <= RAM_HI) region = SEL_RAM;
  end

`ifdef MM_STARVE_GUARD_EN
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  logic [3:0] starve_cnt;

  assign guard_fire = (starve_cnt == SMAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      starve_cnt <= '0;
    else if (state == ACK)
      starve_cnt <= '0;
    else if (!cpu_mreq_n && region == SEL_FB && gpu_req && !guard_fire)
      starve_cnt <= starve_cnt + 4'd1;
  end
`else
  assign guard_fire = 1'b0;
`endif

  always_comb begin
    next_state = state;
    rom_en     = 1'b0;
    rom_addr   = '0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    fb_en_a    = 1'b0;
    fb_we_a    = 1'b0;
    fb_addr_a  = '0;
    fb_en_b    = 1'b0;
    fb_addr_b  = '0;
    gpu_grant  = 1'b0;
    rd_valid   = 1'b0;
    cpu_wait_n = 1'b0;
    bus_err    = 1'b0;
    if (reset_n) begin
      fb_en_b = gpu_req;
      if (gpu_req) begin
        fb_addr_b = gpu_addr_b;
        fb_en_a   = 1'b1;
        fb_addr_a = gpu_addr_a;
        gpu_grant = 1'b1;
      end
      case (state)
        IDLE: if (!cpu_mreq_n) begin
          case (region)
            SEL_ROM: begin
              rom_en     = 1'b1;
              rom_addr   = acc_addr[ROM_AW-1:0];
              next_state = ACK;
            end
            SEL_RAM: begin
              ram_en     = 1'b1;
              ram_we     = ~cpu_wr_n;
              ram_addr   = RAM_AW'(acc_addr - RAM_BASE);
              next_state = ACK;
            end
            SEL_FB: if (!gpu_req || guard_fire) begin
              fb_en_a    = 1'b1;
              fb_we_a    = ~cpu_wr_n;
              fb_addr_a  = FB_AW'(acc_addr - FB_BASE);
              gpu_grant  = 1'b0;
              next_state = ACK;
            end
            default: next_state = ACK;
          endcase
        end
        ACK: begin
          // Enables and address stay up for the BRAM read; write strobe is issue-cycle only.
          cpu_wait_n = 1'b1;
          rd_valid   = lat_wr_n;
          bus_err    = first_ack && (rd_sel == SEL_UNM);
          case (rd_sel)
            SEL_ROM: begin
              rom_en   = 1'b1;
              rom_addr = acc_addr[ROM_AW-1:0];
            end
            SEL_RAM: begin
              ram_en   = 1'b1;
              ram_addr = RAM_AW'(acc_addr - RAM_BASE);
            end
            SEL_FB: begin
              fb_en_a   = 1'b1;
              fb_addr_a = FB_AW'(acc_addr - FB_BASE);
              gpu_grant = 1'b0;
            end
            default: ;
          endcase
          if (cpu_mreq_n) next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      rd_sel    <= SEL_ROM;
      lat_addr  <= '0;
      lat_wr_n  <= 1'b1;
      first_ack <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && next_state == ACK) begin
        rd_sel    <= region;
        lat_addr  <= cpu_addr;
        lat_wr_n  <= cpu_wr_n;
        first_ack <= 1'b1;
      end else begin
        first_ack <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pacman_mem_arbiter.sv
// Bench for pacman_mem_arbiter: directed scenarios plus random CPU/GPU traffic against a cycle-level access model.
module tb_pacman_mem_arbiter;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic        cpu_mreq_n = 1'b1;
  logic        cpu_wr_n = 1'b1;
  logic        gpu_req = 1'b0;
  logic [10:0] gpu_addr_a = '0;
  logic [10:0] gpu_addr_b = '0;
  logic        rom_en, ram_en, ram_we, fb_en_a, fb_we_a, fb_en_b, gpu_grant;
  logic        rd_valid, cpu_wait_n, bus_err;
  logic [13:0] rom_addr;
  logic [11:0] ram_addr;
  logic [10:0] fb_addr_a, fb_addr_b;
  logic [1:0]  rd_sel;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pacman_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_mreq_n(cpu_mreq_n),
    .cpu_wr_n(cpu_wr_n), .gpu_req(gpu_req), .gpu_addr_a(gpu_addr_a), .gpu_addr_b(gpu_addr_b),
    .rom_en(rom_en), .rom_addr(rom_addr), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .fb_en_a(fb_en_a), .fb_we_a(fb_we_a), .fb_addr_a(fb_addr_a), .fb_en_b(fb_en_b),
    .fb_addr_b(fb_addr_b), .gpu_grant(gpu_grant), .rd_sel(rd_sel), .rd_valid(rd_valid),
    .cpu_wait_n(cpu_wait_n), .bus_err(bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Access model: an access is either acknowledged (m_ack) or not yet started.
  bit m_ack = 0, m_first = 0, m_wr_n = 1;
  int m_sel = 0, m_addr = 0, m_starve = 0;

  function automatic int decode(input int a);
    if (a < 16384) return 0;
    if (a >= 'h4000 && a < 'h4000 + 2048) return 2;
    if (a >= 'h4800 && a <= 'h50FF) return 1;
    return 3;
  endfunction

  task automatic cyc(input bit rst, input bit mq, input bit wr, input int a,
                     input bit g, input int ga, input int gb);
    bit guard, active, strobe, cpu_fb, wrn;
    int reg_, acc;
    @(negedge clk);
    reset_n = rst; cpu_mreq_n = mq; cpu_wr_n = wr; cpu_addr = a[15:0];
    gpu_req = g; gpu_addr_a = ga[10:0]; gpu_addr_b = gb[10:0];
    #2;
    if (!rst) begin
      m_ack = 0; m_first = 0; m_sel = 0; m_starve = 0;
      chk("rst_rom_en", rom_en, 0);   chk("rst_ram_en", ram_en, 0);
      chk("rst_ram_we", ram_we, 0);   chk("rst_fb_en_a", fb_en_a, 0);
      chk("rst_fb_we_a", fb_we_a, 0); chk("rst_fb_en_b", fb_en_b, 0);
      chk("rst_wait_n", cpu_wait_n, 0); chk("rst_rd_valid", rd_valid, 0);
      chk("rst_bus_err", bus_err, 0); chk("rst_rd_sel", rd_sel, 0);
      return;
    end
`ifdef MM_STARVE_GUARD_EN
    guard = (m_starve >= STARVE_MAX);
`else
    guard = 0;
`endif
    reg_   = m_ack ? m_sel : decode(a);
    acc    = m_ack ? m_addr : a;
    wrn    = m_ack ? m_wr_n : wr;
    active = m_ack || (!mq && !(reg_ == 2 && g && !guard));
    strobe = !m_ack && !wrn;
    cpu_fb = active && reg_ == 2;
    chk("rom_en", rom_en, active && reg_ == 0);
    chk("rom_addr", rom_addr, (active && reg_ == 0) ? (acc & 'h3FFF) : 0);
    chk("ram_en", ram_en, active && reg_ == 1);
    chk("ram_we", ram_we, active && reg_ == 1 && strobe);
    chk("ram_addr", ram_addr, (active && reg_ == 1) ? ((acc - 'h4800) & 'hFFF) : 0);
    chk("fb_en_a", fb_en_a, g || cpu_fb);
    chk("fb_we_a", fb_we_a, cpu_fb && strobe);
    chk("fb_addr_a", fb_addr_a, cpu_fb ? ((acc - 'h4000) & 'h7FF) : (g ? ga : 0));
    chk("fb_en_b", fb_en_b, g);
    chk("fb_addr_b", fb_addr_b, g ? gb : 0);
    chk("gpu_grant", gpu_grant, g && !cpu_fb);
    chk("cpu_wait_n", cpu_wait_n, m_ack);
    chk("rd_valid", rd_valid, m_ack && m_wr_n);
    chk("bus_err", bus_err, m_ack && m_first && m_sel == 3);
    chk("rd_sel", rd_sel, m_sel);
    if (m_ack) begin
      m_first = 0; m_starve = 0;
      if (mq) m_ack = 0;
    end else if (!mq) begin
      if (active) begin
        m_ack = 1; m_first = 1; m_sel = reg_; m_addr = a; m_wr_n = wr;
      end else if (m_starve < STARVE_MAX) begin
        m_starve++;
      end
    end
  endtask

  function automatic int pick_addr();
    case ($urandom_range(0, 11))
      0: return 'h3FFF;  1: return 'h4000;  2: return 'h47FF;  3: return 'h4800;
      4: return 'h50FF;  5: return 'h5100;  6: return 'hFFFF;  7: return 'h0000;
      8: return $urandom_range('h4000, 'h47FF);
      9: return $urandom_range('h4800, 'h50FF);
      default: return $urandom_range(0, 'hFFFF);
    endcase
  endfunction

  initial begin
    int n;
    bit mq, wr;
    int a;
    cyc(0, 1, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0);

    // ROM read
    cyc(1, 0, 1, 'h1234, 0, 0, 0);
    chk("rom_issue_addr", rom_addr, 'h1234);
    cyc(1, 0, 1, 'h1234, 0, 0, 0);
    chk("rom_ack_valid", rd_valid, 1);
    cyc(1, 1, 1, 'h1234, 0, 0, 0);

    // RAM write then read back
    n = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 'h4805, 0, 0, 0);
      if (ram_we) n++;
    end
    chk("ram_we_pulses", n, 1);
    cyc(1, 1, 1, 0, 0, 0, 0);
    cyc(1, 0, 1, 'h4805, 0, 0, 0);
    cyc(1, 0, 1, 'h4805, 0, 0, 0);
    chk("ram_rd_sel", rd_sel, 1);
    cyc(1, 1, 1, 0, 0, 0, 0);

    // CPU FB read against continuous GPU demand
    n = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 1, 'h4010, 1, 'h200, 'h300);
      if (!cpu_wait_n) n++;
    end
`ifdef MM_STARVE_GUARD_EN
    chk("starve_wait_cycles", n, STARVE_MAX + 1);
`else
    chk("starve_wait_cycles", n, 10);
`endif
    cyc(1, 1, 1, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0);

    // Unmapped read
    n = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 1, 'h6000, 0, 0, 0);
      if (bus_err) n++;
    end
    chk("unmapped_err_pulses", n, 1);
    chk("unmapped_rd_sel", rd_sel, 3);
    cyc(1, 1, 1, 0, 0, 0, 0);

    // Reset during RAM ACK
    cyc(1, 0, 1, 'h4900, 0, 0, 0);
    cyc(1, 0, 1, 'h4900, 0, 0, 0);
    cyc(0, 0, 1, 'h4900, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0);

    // GPU pass-through, CPU idle
    cyc(1, 1, 1, 0, 1, 'h123, 'h456);
    chk("gpu_pass_a", fb_addr_a, 'h123);

    // Random traffic
    mq = 1; wr = 1; a = 0;
    for (int i = 0; i < 3000; i++) begin
      if (mq) begin
        if ($urandom_range(0, 1) == 1) begin
          mq = 0; wr = $urandom_range(0, 1) == 1; a = pick_addr();
        end
      end else if (m_ack) begin
        if ($urandom_range(0, 1) == 1) mq = 1;
        else if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 'hFFFF);
      end
      cyc($urandom_range(0, 199) != 0, mq, wr, a, $urandom_range(0, 9) < 4,
          $urandom_range(0, 2047), $urandom_range(0, 2047));
      if (!reset_n) mq = 1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
